immediate_encoder: RTL and testbench
====================================

# immediate_encoder

Inverse of the immediate decode path in the monocycle core: accepts a 32-bit signed immediate, an instruction-type code and a base instruction word, and packs the immediate into the type's RISC-V bit positions. It also range-checks the immediate. Results are buffered in a 2-entry output queue behind valid/ready handshakes. It sits on the instruction-memory loader / self-test side, so that decoding any error-free output reproduces the original immediate.

## Interface
- No parameters (widths fixed at 32-bit instruction, 3-bit type, 16-bit counters).
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  encoder can accept; registered, no combinational path from out_ready.
- in_instr_type  input  3  000 I, 001 S, 101 B, 110 J; all other codes unsupported.
- in_immediate  input  32  signed immediate, byte offset for B/J.
- in_base  input  32  opcode/register/funct bits; bits not owned by the immediate pass through.
- out_valid  output  1  queue head valid.
- out_ready  input  1  consumer accepts head.
- out_instruction  output  32  packed instruction word.
- out_error  output  1  immediate out of range, misaligned, or type unsupported.
- encoded_count  output  16  accepted requests, saturating.
- error_count  output  16  accepted requests with error, saturating.

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready.
- Owned bits and packing per type (imm = in_immediate):
  - I: [31:20]=imm[11:0]. Legal if imm[31:11] all equal.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Same legality rule as I.
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. Legal if imm[31:12] all equal and imm[0]=0.
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]. Legal if imm[31:20] all equal and imm[0]=0.
- All non-owned bits are copied from in_base.
- Illegal immediate: owned bits forced to 0, non-owned bits from in_base, out_error=1.
- Unsupported type: out_instruction=in_base unchanged, out_error=1.
- Queue: 2-entry FIFO of {instruction, error}. Strict in-order delivery; no entry dropped or duplicated.
- Queue states by occupancy:
  - EMPTY (0): out_valid=0, in_ready=1.
  - ONE (1): out_valid=1, in_ready=1.
  - FULL (2): out_valid=1, in_ready=0.
- Queue transitions: push-only +1; pop-only −1; push and pop together hold occupancy. Push is impossible in FULL, even if out_ready=1 in that cycle.
- encoded_count +1 per input transfer; error_count +1 per input transfer flagged as error. Both hold at 16'hFFFF.

## Timing
- Reset values: out_valid=0, in_ready=1, out_instruction=0, out_error=0, both counters 0, queue EMPTY.
- Reset mid-operation discards all queued entries. in_valid is ignored while rst=1.
- Latency: request accepted at edge N appears at the head with out_valid=1 after edge N, if the queue was EMPTY or the head popped at N.
- Throughput: one request per cycle while out_ready=1.
- out_instruction and out_error stay stable while out_valid=1 and out_ready=0.
- in_ready reflects occupancy after the current edge only; it deasserts the cycle after the queue reaches FULL.
- Counters update on the same edge as the input transfer.

## Test plan
- I-type, imm=32'hFFFFFFFF, base=32'h00000013 -> out_instruction=32'hFFF00013, out_error=0, visible one cycle after accept.
- S-type, imm=32'h000007FF, base=32'h00002023 -> 32'h7E002FA3, error 0. B-type, imm=32'h00000800, base=32'h00000063 -> 32'h000000E3, error 0.
- Errors:
  - J-type, imm=32'h00000001, base=32'hFFFFF06F -> 32'h0000006F, error 1, error_count=1.
  - I-type, imm=32'h00000800 -> error 1.
  - type 3'b011, base=32'h12345678 -> 32'h12345678, error 1.
- Backpressure: out_ready=0, drive 3 consecutive valid requests A,B,C -> A,B accepted, in_ready=0 from the cycle after B, C held. Then out_ready=1 -> A,B,C delivered in order; encoded_count=3.
- Reset mid-operation: queue FULL, pulse rst one cycle -> out_valid=0, in_ready=1, counters 0 on the next cycle; the next request is delivered normally.
- Random round-trip: 10k random legal type/immediate pairs -> decoding out_instruction with the core's immediate decoder returns in_immediate. Force encoded_count to 16'hFFFE, then send 3 requests -> counter stays at 16'hFFFF.

Source files
------------

// File: rtl/immediate_encoder.sv
// Packs a signed immediate into RISC-V I/S/B/J bit positions with range checking,
// buffered through a 2-entry valid/ready output queue with saturating counters.
module immediate_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_instr_type,
  input  logic [31:0] in_immediate,
  input  logic [31:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic        out_error,
  output logic [15:0] encoded_count,
  output logic [15:0] error_count
);

  localparam logic [2:0] TYPE_I = 3'b000;
  localparam logic [2:0] TYPE_S = 3'b001;
  localparam logic [2:0] TYPE_B = 3'b101;
  localparam logic [2:0] TYPE_J = 3'b110;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t      state_q, state_d;
  logic [32:0] slot0_q, slot0_d;
  logic [32:0] slot1_q, slot1_d;
  logic [15:0] enc_cnt_q, enc_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        legal;
  logic [31:0] imm_g;
  logic        push;
  logic        pop;

  // An illegal immediate is zeroed before packing so its owned bits come out as 0.
  always_comb begin
    enc_instr = in_base;
    enc_err   = 1'b0;
    legal     = 1'b1;
    imm_g     = in_immediate;
    case (in_instr_type)
      TYPE_I, TYPE_S: legal = (&in_immediate[31:11]) | ~(|in_immediate[31:11]);
      TYPE_B:         legal = ((&in_immediate[31:12]) | ~(|in_immediate[31:12])) & ~in_immediate[0];
      TYPE_J:         legal = ((&in_immediate[31:20]) | ~(|in_immediate[31:20])) & ~in_immediate[0];
      default:        legal = 1'b0;
    endcase
    if (!legal) imm_g = '0;
    case (in_instr_type)
      TYPE_I: begin
        enc_instr[31:20] = imm_g[11:0];
        enc_err          = ~legal;
      end
      TYPE_S: begin
        enc_instr[31:25] = imm_g[11:5];
        enc_instr[11:7]  = imm_g[4:0];
        enc_err          = ~legal;
      end
      TYPE_B: begin
        enc_instr[31:25] = {imm_g[12], imm_g[10:5]};
        enc_instr[11:7]  = {imm_g[4:1], imm_g[11]};
        enc_err          = ~legal;
      end
      TYPE_J: begin
        enc_instr[31:12] = {imm_g[20], imm_g[10:1], imm_g[11], imm_g[19:12]};
        enc_err          = ~legal;
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign in_ready        = (state_q != FULL);
  assign out_valid       = (state_q != EMPTY);
  assign out_instruction = slot0_q[31:0];
  assign out_error       = slot0_q[32];
  assign encoded_count   = enc_cnt_q;
  assign error_count     = err_cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // slot0 is always the head; slot1 only holds the second entry when FULL.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          slot0_d = {enc_err, enc_instr};
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          slot0_d = {enc_err, enc_instr};
        end else if (push) begin
          slot1_d = {enc_err, enc_instr};
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          slot0_d = slot1_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push && enc_cnt_q != 16'hFFFF) enc_cnt_d = enc_cnt_q + 16'd1;
    if (push && enc_err && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      slot0_q   <= '0;
      slot1_q   <= '0;
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_immediate_encoder.sv
// Randomized and directed checks of immediate_encoder against a per-bit placement
// model with a FIFO scoreboard and a RISC-V immediate decoder for round trips.
module tb_immediate_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_instr_type = '0;
  logic [31:0] in_immediate = '0;
  logic [31:0] in_base = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instruction;
  logic        out_error;
  logic [15:0] encoded_count;
  logic [15:0] error_count;

  immediate_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr_type(in_instr_type), .in_immediate(in_immediate), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_error(out_error), .encoded_count(encoded_count), .error_count(error_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  ty;
    logic [31:0] imm;
  } ent_t;

  ent_t q[$];
  int   m_enc = 0;
  int   m_err = 0;
  int   m_acc = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Which immediate bit lands at instruction bit p, or -1 if p is not owned.
  function automatic int src_bit(input logic [2:0] ty, input int p);
    case (ty)
      3'b000: return (p >= 20) ? p - 20 : -1;
      3'b001: return (p >= 25) ? p - 20 : ((p >= 7 && p <= 11) ? p - 7 : -1);
      3'b101: begin
        if (p == 31) return 12;
        if (p == 7) return 11;
        if (p >= 25) return p - 20;
        if (p >= 8 && p <= 11) return p - 7;
        return -1;
      end
      3'b110: begin
        if (p == 31) return 20;
        if (p == 20) return 11;
        if (p >= 21) return p - 20;
        if (p >= 12) return p;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic logic [32:0] model(input logic [2:0] ty, input logic [31:0] imm,
                                        input logic [31:0] base);
    longint s = longint'($signed(imm));
    logic ok;
    logic [31:0] r = base;
    int b;
    case (ty)
      3'b000, 3'b001: ok = (s >= -2048) && (s <= 2047);
      3'b101:         ok = (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
      3'b110:         ok = (s >= -1048576) && (s <= 1048575) && (imm[0] == 1'b0);
      default:        return {1'b1, base};
    endcase
    for (int p = 0; p < 32; p++) begin
      b = src_bit(ty, p);
      if (b >= 0) r[p] = ok ? imm[b] : 1'b0;
    end
    return {~ok, r};
  endfunction

  function automatic logic [31:0] decode(input logic [2:0] ty, input logic [31:0] i);
    case (ty)
      3'b000:  return {{20{i[31]}}, i[31:20]};
      3'b001:  return {{20{i[31]}}, i[31:25], i[11:7]};
      3'b101:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  // One clock: check outputs against the scoreboard, then apply the upcoming edge to it.
  task automatic tick();
    logic [32:0] e;
    ent_t        n;
    bit          was_full;
    @(negedge clk);
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("encoded_count", 32'(encoded_count), m_enc);
      chk("error_count", 32'(error_count), m_err);
      if (q.size() > 0) begin
        chk("head_instr", out_instruction, q[0].instr);
        chk("head_err", 32'(out_error), 32'(q[0].err));
      end
    end
    if (rst) begin
      q.delete();
      m_enc = 0;
      m_err = 0;
    end else begin
      was_full = (q.size() == 2);
      if (q.size() > 0 && out_ready) begin
        if (!q[0].err) chk("round_trip", decode(q[0].ty, out_instruction), q[0].imm);
        void'(q.pop_front());
      end
      if (in_valid && !was_full) begin
        e = model(in_instr_type, in_immediate, in_base);
        n.instr = e[31:0];
        n.err   = e[32];
        n.ty    = in_instr_type;
        n.imm   = in_immediate;
        q.push_back(n);
        m_acc++;
        if (m_enc < 65535) m_enc++;
        if (e[32] && m_err < 65535) m_err++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_one(input string tag, input logic [2:0] ty, input logic [31:0] imm,
                          input logic [31:0] base, input logic [31:0] exp_i, input logic exp_e);
    in_instr_type = ty;
    in_immediate  = imm;
    in_base       = base;
    in_valid      = 1'b1;
    out_ready     = 1'b0;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instruction, exp_i);
    chk({tag, "_err"}, 32'(out_error), 32'(exp_e));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic rand_req(input bit legal_only);
    int v;
    logic [2:0] tys[4] = '{3'b000, 3'b001, 3'b101, 3'b110};
    in_base = $urandom;
    if (!legal_only && $urandom_range(0, 9) == 0) begin
      in_instr_type = 3'($urandom_range(0, 7));
      in_immediate  = $urandom;
    end else begin
      in_instr_type = tys[$urandom_range(0, 3)];
      case (in_instr_type)
        3'b000, 3'b001: v = int'($urandom_range(0, 4095)) - 2048;
        3'b101:         v = (int'($urandom_range(0, 4095)) - 2048) * 2;
        default:        v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      endcase
      in_immediate = v;
    end
  endtask

  initial begin
    int cyc;
    int start;
    do_reset();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_instr", out_instruction, 32'h0);
    chk("rst_err", 32'(out_error), 32'd0);
    chk("rst_enc_cnt", 32'(encoded_count), 32'd0);
    chk("rst_err_cnt", 32'(error_count), 32'd0);

    send_one("i_neg1", 3'b000, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0);
    send_one("s_7ff",  3'b001, 32'h000007FF, 32'h00002023, 32'h7E002FA3, 1'b0);
    send_one("b_800",  3'b101, 32'h00000800, 32'h00000063, 32'h000000E3, 1'b0);
    send_one("j_odd",  3'b110, 32'h00000001, 32'hFFFFF06F, 32'h0000006F, 1'b1);
    chk("j_odd_err_cnt", 32'(error_count), 32'd1);
    send_one("i_range", 3'b000, 32'h00000800, 32'h00000013, 32'h00000013, 1'b1);
    send_one("bad_type", 3'b011, 32'h00000004, 32'h12345678, 32'h12345678, 1'b1);

    // Backpressure: A and B fill the queue, C waits.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr_type = 3'b000;
    in_base = 32'h00000013;
    in_immediate = 32'd1;  tick();
    chk("bp_rdy_after_a", 32'(in_ready), 32'd1);
    in_immediate = 32'd2;  tick();
    chk("bp_rdy_after_b", 32'(in_ready), 32'd0);
    in_immediate = 32'd3;  tick();
    chk("bp_c_held", 32'(in_ready), 32'd0);
    chk("bp_head_a", out_instruction, 32'h00100013);
    out_ready = 1'b1;      tick();
    chk("bp_head_b", out_instruction, 32'h00200013);
    tick();
    in_valid = 1'b0;
    chk("bp_head_c", out_instruction, 32'h00300013);
    tick();
    chk("bp_enc_cnt", 32'(encoded_count), 32'd3);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset with the queue full.
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    chk("mid_full", 32'(in_ready), 32'd0);
    do_reset();
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_enc_cnt", 32'(encoded_count), 32'd0);
    chk("mid_err_cnt", 32'(error_count), 32'd0);
    send_one("post_rst", 3'b001, 32'hFFFFF800, 32'h00002023, 32'h80002023, 1'b0);

    // Random traffic with random backpressure.
    start = m_acc;
    cyc = 0;
    while (m_acc - start < 10000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 8);
      rand_req(1'b0);
      tick();
      cyc++;
    end
    chk("rand_budget", 32'(m_acc - start >= 10000), 32'd1);

    // Stream legal requests up to the saturation edge of the counters.
    out_ready = 1'b1;
    in_valid = 1'b1;
    cyc = 0;
    while (m_enc < 65534 && cyc < 70000) begin
      rand_req(1'b1);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    tick();
    chk("cnt_fffe", 32'(encoded_count), 32'h0000FFFE);
    start = m_acc;
    in_valid = 1'b1;
    cyc = 0;
    while (m_acc - start < 3 && cyc < 20) begin
      rand_req(1'b1);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    tick();
    chk("sat_accepts", 32'(m_acc - start), 32'd3);
    chk("cnt_sat", 32'(encoded_count), 32'h0000FFFF);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
